// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer for the softcore front end.
// Issues one word-addressed fetch at a time, holds the returned instruction
// for decode, and squashes wrong-path fetches when a branch redirect arrives.
module pc_fetch #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pc_sel,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    // Set when the outstanding request belongs to a squashed path; its
    // response must be thrown away instead of reaching decode.
    logic                  drop;

    // The request is only offered in S_REQ and never while reset is held,
    // so memory cannot accept a fetch during the reset cycle.
    assign imem_req_valid = (state == S_REQ) && !rst;
    assign imem_req_addr  = pc;
    // PC only advances once decode has taken the held instruction, so the
    // current PC is always the address of the instruction being offered.
    assign instr_pc       = pc;

    // Fetch sequencer: redirect outranks every handshake; reset outranks all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr_valid <= 1'b0;
            instr_out   <= '0;
        end else if (pc_sel) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        // The fetch just accepted is already wrong-path.
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A simultaneous instr_ready is not a transfer; decode
                    // squashes on pc_sel itself.
                    state <= S_REQ;
                end
                default: begin
                    state <= S_REQ;
                    drop  <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop) begin
                            // Refetch from the redirected PC.
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            instr_out   <= imem_rsp_data;
                            instr_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc + ADDR_WIDTH'(1);
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                    drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized bench for pc_fetch: a memory with random accept/latency, random
// decode back-pressure, random redirects and reset pulses, checked against a
// transaction-level model of the architectural PC and outstanding fetch.
module tb_pc_fetch;

    localparam int              AW     = 16;
    localparam int              IW     = 16;
    localparam logic [AW-1:0]   RST_PC = 16'hFFFF;
    localparam int              NCYC   = 4000;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_sel;
    logic [AW-1:0] branch_target;
    logic          imem_req_valid;
    logic          imem_req_ready;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [IW-1:0] imem_rsp_data;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_out;
    logic [AW-1:0] instr_pc;

    pc_fetch #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_sel         (pc_sel),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Memory contents: a bijection of the address so a wrong-path word can
    // never masquerade as the right one.
    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'h0000_9E37;
        return t[15:0] ^ 16'h5A5A;
    endfunction

    // Reference model state
    logic [AW-1:0] m_pc;        // architectural PC
    logic          m_out;       // a fetch is outstanding
    logic          m_stale;     // outstanding fetch was overtaken by a redirect
    logic          exp_valid;   // instruction expected to be offered to decode
    logic          prev_rst;
    // Memory responder state
    logic          mem_pending;
    int            mem_cnt;
    logic [AW-1:0] mem_addr;
    int            idle;

    // Main stimulus / checking loop: outputs are checked at the falling edge,
    // then the next cycle's inputs are driven and the model advanced.
    initial begin
        logic hs, rsp_counts, xfer;
        rst            = 1'b1;
        pc_sel         = 1'b0;
        branch_target  = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        m_pc           = RST_PC;
        m_out          = 1'b0;
        m_stale        = 1'b0;
        exp_valid      = 1'b0;
        prev_rst       = 1'b1;
        mem_pending    = 1'b0;
        mem_cnt        = 0;
        mem_addr       = '0;
        idle           = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (prev_rst) begin
                check("rst_instr_out", 32'(instr_out), 32'd0);
                check("rst_instr_pc", 32'(instr_pc), 32'(RST_PC));
            end
            check("instr_valid", 32'(instr_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("instr_pc", 32'(instr_pc), 32'(m_pc));
                check("instr_out", 32'(instr_out), 32'(mem_word(m_pc)));
            end

            // Drive inputs for the coming edge
            rst    = (cyc < 3) || ($urandom_range(0, 299) == 0);
            pc_sel = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 3) == 0)
                branch_target = 16'hFFFF;
            else
                branch_target = AW'($urandom);
            instr_ready = ($urandom_range(0, 1) == 1);

            imem_rsp_valid = 1'b0;
            imem_rsp_data  = IW'($urandom);
            if (mem_pending && mem_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(mem_addr);
                mem_pending    = 1'b0;
            end else if (mem_pending) begin
                mem_cnt--;
            end else if ($urandom_range(0, 31) == 0) begin
                imem_rsp_valid = 1'b1;   // stray response, must be ignored
            end
            imem_req_ready = !mem_pending && ($urandom_range(0, 3) != 0);

            #1;
            check("req_valid", 32'(imem_req_valid), 32'(!rst && !m_out && !exp_valid));
            hs = imem_req_valid && imem_req_ready;
            if (hs) begin
                check("req_addr", 32'(imem_req_addr), 32'(m_pc));
                mem_pending = 1'b1;
                mem_addr    = imem_req_addr;
                mem_cnt     = $urandom_range(0, 2);
            end

            // Advance the model across the coming edge
            rsp_counts = imem_rsp_valid && m_out;
            xfer       = exp_valid && instr_ready && !pc_sel;
            if (rst) begin
                m_pc      = RST_PC;
                m_out     = 1'b0;
                m_stale   = 1'b0;
                exp_valid = 1'b0;
                idle      = 0;
            end else begin
                if (rsp_counts) begin
                    m_out     = 1'b0;
                    exp_valid = !m_stale && !pc_sel;
                    m_stale   = 1'b0;
                end
                if (hs) begin
                    m_out   = 1'b1;
                    m_stale = 1'b0;
                end
                if (pc_sel) begin
                    m_pc      = branch_target;
                    exp_valid = 1'b0;
                    if (m_out) m_stale = 1'b1;
                    idle = 0;
                end else if (xfer) begin
                    m_pc      = m_pc + 16'd1;
                    exp_valid = 1'b0;
                    idle      = 0;
                end else begin
                    idle++;
                end
                if (idle > 200) begin
                    check("progress", 32'(idle), 32'd0);
                    idle = 0;
                end
            end
            prev_rst = rst;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
